// File: rtl/lfsr_ctrl_pkg.sv
// Shared types and default constants for the LFSR step-enable controller.
package lfsr_ctrl_pkg;

   typedef enum logic {
      PAUSED = 1'b0,
      RUN    = 1'b1
   } state_t;

   localparam int unsigned SLOW_DIV_DEF  = 50_000_000;
   localparam int unsigned FAST_DIV_DEF  = 6_250_000;
   localparam int unsigned DB_CYCLES_DEF = 500_000;
   localparam int unsigned STEP_CNT_W    = 16;

endpackage

// File: rtl/key_debounce.sv
// Pushbutton conditioning: 2-flop synchronizer, stable-sample debounce,
// and a one-cycle press pulse on the debounced 1->0 transition.
module key_debounce
   import lfsr_ctrl_pkg::*;
#(
   parameter int unsigned DB_CYCLES = DB_CYCLES_DEF
) (
   input  logic clk50mhz,
   input  logic rst,
   input  logic key_n,
   output logic press
);

   localparam int unsigned     DB_W    = (DB_CYCLES > 1) ? $clog2(DB_CYCLES) : 1;
   localparam logic [DB_W-1:0] DB_LAST = DB_W'(DB_CYCLES - 1);

   logic            key_s1;
   logic            key_s2;
   logic            key_db;
   logic [DB_W-1:0] stable_cnt;

   // two-flop synchronizer, idles released (high)
   always_ff @(posedge clk50mhz) begin
      if (rst) begin
         key_s1 <= 1'b1;
         key_s2 <= 1'b1;
      end else begin
         key_s1 <= key_n;
         key_s2 <= key_s1;
      end
   end

   // accept a new level after DB_CYCLES consecutive differing samples
   always_ff @(posedge clk50mhz) begin
      if (rst) begin
         key_db     <= 1'b1;
         stable_cnt <= '0;
         press      <= 1'b0;
      end else begin
         press <= 1'b0;
         if (key_s2 != key_db) begin
            if (stable_cnt == DB_LAST) begin
               key_db     <= key_s2;
               stable_cnt <= '0;
               press      <= ~key_s2;
            end else begin
               stable_cnt <= stable_cnt + DB_W'(1);
            end
         end else begin
            stable_cnt <= '0;
         end
      end
   end

endmodule

// File: rtl/lfsr_step_ctrl.sv
// Step-enable generator for the LFSR display stage: free-run at a slow or
// fast rate, or single-step from the debounced key while paused.
module lfsr_step_ctrl
   import lfsr_ctrl_pkg::*;
#(
   parameter int unsigned SLOW_DIV  = SLOW_DIV_DEF,
   parameter int unsigned FAST_DIV  = FAST_DIV_DEF,
   parameter int unsigned DB_CYCLES = DB_CYCLES_DEF,
   parameter int unsigned CNT_W     = 26
) (
   input  logic                  clk50mhz,
   input  logic                  rst,
   input  logic                  key_step_n,
   input  logic                  sw_run,
   input  logic                  sw_fast,
   output logic                  step_en,
   output logic                  led_step,
   output logic                  running,
   output logic [STEP_CNT_W-1:0] step_count
);

   localparam logic [CNT_W-1:0] SLOW_TC = CNT_W'(SLOW_DIV - 1);
   localparam logic [CNT_W-1:0] FAST_TC = CNT_W'(FAST_DIV - 1);

   logic             run_s1;
   logic             run_s2;
   logic             fast_s1;
   logic             fast_s2;
   logic             press;
   state_t           state;
   state_t           state_nx;
   logic [CNT_W-1:0] presc;
   logic [CNT_W-1:0] presc_nx;
   logic [CNT_W-1:0] term;
   logic             step_nx;

   key_debounce #(
      .DB_CYCLES (DB_CYCLES)
   ) u_key_debounce (
      .clk50mhz (clk50mhz),
      .rst      (rst),
      .key_n    (key_step_n),
      .press    (press)
   );

   // two-flop synchronizers for the mode switches
   always_ff @(posedge clk50mhz) begin
      if (rst) begin
         run_s1  <= 1'b0;
         run_s2  <= 1'b0;
         fast_s1 <= 1'b0;
         fast_s2 <= 1'b0;
      end else begin
         run_s1  <= sw_run;
         run_s2  <= run_s1;
         fast_s1 <= sw_fast;
         fast_s2 <= fast_s1;
      end
   end

   // FSM state register
   always_ff @(posedge clk50mhz) begin
      if (rst) begin
         state <= PAUSED;
      end else begin
         state <= state_nx;
      end
   end

   // next state, prescaler and strobe decision; >= lets a mid-count rate
   // drop fire immediately instead of wrapping the counter
   always_comb begin
      state_nx = state;
      presc_nx = presc;
      step_nx  = 1'b0;
      term     = fast_s2 ? FAST_TC : SLOW_TC;
      case (state)
         PAUSED: begin
            if (run_s2) begin
               state_nx = RUN;
               presc_nx = '0;
            end else if (press) begin
               step_nx = 1'b1;
            end
         end
         RUN: begin
            if (!run_s2) begin
               state_nx = PAUSED;
               presc_nx = '0;
            end else if (presc >= term) begin
               presc_nx = '0;
               step_nx  = 1'b1;
            end else begin
               presc_nx = presc + CNT_W'(1);
            end
         end
         default: begin
            state_nx = PAUSED;
            presc_nx = '0;
         end
      endcase
   end

   // registered prescaler and outputs
   always_ff @(posedge clk50mhz) begin
      if (rst) begin
         presc      <= '0;
         step_en    <= 1'b0;
         led_step   <= 1'b0;
         running    <= 1'b0;
         step_count <= '0;
      end else begin
         presc   <= presc_nx;
         step_en <= step_nx;
         running <= (state_nx == RUN);
         if (step_nx) begin
            led_step   <= ~led_step;
            step_count <= step_count + STEP_CNT_W'(1);
         end
      end
   end

endmodule

// File: tb/tb_lfsr_step_ctrl.sv
// Self-checking bench for lfsr_step_ctrl with a cycle-level behavioural model.
module tb_lfsr_step_ctrl;

   localparam int unsigned SLOW = 8;
   localparam int unsigned FAST = 2;
   localparam int unsigned DB   = 4;
   localparam int unsigned CW   = 4;

   logic        clk50mhz = 1'b0;
   logic        rst;
   logic        key_step_n;
   logic        sw_run;
   logic        sw_fast;
   logic        step_en;
   logic        led_step;
   logic        running;
   logic [15:0] step_count;

   int compared   = 0;
   int mismatched = 0;

   lfsr_step_ctrl #(
      .SLOW_DIV  (SLOW),
      .FAST_DIV  (FAST),
      .DB_CYCLES (DB),
      .CNT_W     (CW)
   ) dut (
      .clk50mhz   (clk50mhz),
      .rst        (rst),
      .key_step_n (key_step_n),
      .sw_run     (sw_run),
      .sw_fast    (sw_fast),
      .step_en    (step_en),
      .led_step   (led_step),
      .running    (running),
      .step_count (step_count)
   );

   always #5 clk50mhz = ~clk50mhz;

   // ---------------- behavioural model ----------------
   // Inputs are seen two edges late; the key level flips after DB matching
   // differing samples; in RUN a strobe comes once `div` cycles have elapsed
   // since entry or since the previous strobe.
   bit          model_ok = 1'b0;
   bit          ks1, ks2, rs1, rs2, fs1, fs2;
   bit          m_db, m_press, m_run;
   int          run_len, since;
   bit          e_step, e_led;
   logic [15:0] e_cnt;

   always @(posedge clk50mhz) begin
      bit stp;
      bit np;
      int div;
      if (rst) begin
         ks1 = 1; ks2 = 1; rs1 = 0; rs2 = 0; fs1 = 0; fs2 = 0;
         m_db = 1; run_len = 0; m_press = 0; m_run = 0; since = 0;
         e_step = 0; e_led = 0; e_cnt = 16'd0;
         model_ok = 1'b1;
      end else begin
         stp = 0;
         if (!m_run) begin
            if (rs2) begin
               m_run = 1; since = 0;
            end else if (m_press) begin
               stp = 1;
            end
         end else if (!rs2) begin
            m_run = 0; since = 0;
         end else begin
            div = fs2 ? int'(FAST) : int'(SLOW);
            if (since + 1 >= div) begin
               stp = 1; since = 0;
            end else begin
               since++;
            end
         end
         np = 0;
         if (ks2 != m_db) begin
            run_len++;
            if (run_len == int'(DB)) begin
               m_db = ks2; run_len = 0; np = (ks2 == 1'b0);
            end
         end else begin
            run_len = 0;
         end
         m_press = np;
         ks2 = ks1; ks1 = key_step_n;
         rs2 = rs1; rs1 = sw_run;
         fs2 = fs1; fs1 = sw_fast;
         e_step = stp;
         if (stp) begin
            e_led = ~e_led;
            e_cnt = e_cnt + 16'd1;
         end
      end
   end

   // every-cycle comparison of all outputs against the model
   always @(negedge clk50mhz) begin
      if (model_ok) begin
         compared++;
         if (step_en !== e_step || led_step !== e_led || running !== m_run || step_count !== e_cnt) begin
            mismatched++;
            $display("FAIL model_cycle t=%0t: got step=%b led=%b run=%b cnt=%0d, expected step=%b led=%b run=%b cnt=%0d",
                     $time, step_en, led_step, running, step_count, e_step, e_led, m_run, e_cnt);
         end
      end
   end

   // ---------------- helpers ----------------
   task automatic check(input string name, input int act, input int exp);
      compared++;
      if (act != exp) begin
         mismatched++;
         $display("FAIL %s: got %0d expected %0d", name, act, exp);
      end
   endtask

   task automatic check_range(input string name, input int act, input int lo, input int hi);
      compared++;
      if (act < lo || act > hi) begin
         mismatched++;
         $display("FAIL %s: got %0d expected %0d..%0d", name, act, lo, hi);
      end
   endtask

   task automatic tick(input int n);
      repeat (n) @(negedge clk50mhz);
   endtask

   task automatic cyc(input int n, output int p);
      p = 0;
      repeat (n) begin
         @(negedge clk50mhz);
         if (step_en === 1'b1) p++;
      end
   endtask

   task automatic wait_step(output bit ok);
      ok = 0;
      for (int i = 0; i < 40; i++) begin
         @(negedge clk50mhz);
         if (step_en === 1'b1) begin
            ok = 1;
            break;
         end
      end
   endtask

   // ---------------- stimulus ----------------
   initial begin
      int p, tot, lat, rise, first, last, npulse, badgap, hold;
      bit ok;

      rst = 1'b1; key_step_n = 1'b1; sw_run = 1'b0; sw_fast = 1'b0;
      tick(3);
      rst = 1'b0;

      // idle after reset
      cyc(100, p);
      check("idle_pulses", p, 0);
      check("idle_count", int'(step_count), 0);
      check("idle_running", int'(running), 0);

      // paused stepping
      tot = 0;
      repeat (3) begin
         key_step_n = 1'b0; cyc(10, p); tot += p;
         key_step_n = 1'b1; cyc(10, p); tot += p;
      end
      check("step_pulses", tot, 3);
      check("step_count_3", int'(step_count), 3);
      check("step_led", int'(led_step), 1);

      // bounce rejection then a clean fall
      tot = 0;
      for (int i = 0; i < 10; i++) begin
         key_step_n = ~key_step_n; cyc(2, p); tot += p;
      end
      key_step_n = 1'b0;
      lat = 0;
      for (int i = 1; i <= 12; i++) begin
         @(negedge clk50mhz);
         if (step_en === 1'b1) begin
            tot++;
            if (lat == 0) lat = i;
         end
      end
      check_range("bounce_latency", lat, 1, 8);
      key_step_n = 1'b1; cyc(12, p); tot += p;
      check("bounce_pulses", tot, 1);
      check("bounce_count", int'(step_count), 4);

      // slow run
      sw_run = 1'b1;
      rise = 0; first = 0; last = 0; npulse = 0; badgap = 0;
      for (int i = 1; i <= 80; i++) begin
         @(negedge clk50mhz);
         if (running === 1'b1 && rise == 0) rise = i;
         if (step_en === 1'b1) begin
            npulse++;
            if (first == 0) first = i;
            else if (i - last != 8) badgap++;
            last = i;
         end
      end
      check("slow_first_delay", first - rise, 8);
      check_range("slow_pulses", npulse, 9, 10);
      check("slow_gaps", badgap, 0);

      // mid-count rate change at prescaler=5
      wait_step(ok);
      check("wait_slow_step", int'(ok), 1);
      cyc(5, p);
      check("pre_fast_quiet", p, 0);
      sw_fast = 1'b1;
      lat = 0;
      for (int i = 1; i <= 6; i++) begin
         @(negedge clk50mhz);
         if (step_en === 1'b1 && lat == 0) begin
            lat = i;
            break;
         end
      end
      check_range("fast_latency", lat, 1, 3);
      key_step_n = 1'b0;
      npulse = 0; badgap = 0; last = 0;
      for (int i = 1; i <= 20; i++) begin
         @(negedge clk50mhz);
         if (i == 10) key_step_n = 1'b1;
         if (step_en === 1'b1) begin
            npulse++;
            if (i - last != 2) badgap++;
            last = i;
         end
      end
      check("fast_pulses", npulse, 10);
      check("fast_gaps", badgap, 0);
      tick(10);

      // reset at prescaler=6 while running
      sw_fast = 1'b0;
      wait_step(ok);
      check("wait_slow_step2", int'(ok), 1);
      cyc(6, p);
      check("pre_rst_quiet", p, 0);
      rst = 1'b1; tick(1); rst = 1'b0;
      check("rst_count", int'(step_count), 0);
      cyc(8, p);
      check("post_rst_quiet", p, 0);
      wait_step(ok);
      check("post_rst_step", int'(ok), 1);
      check("post_rst_count", int'(step_count), 1);

      // randomized traffic against the model
      hold = 0;
      for (int i = 0; i < 1500; i++) begin
         if ($urandom_range(0, 59) == 0) sw_run = ~sw_run;
         if ($urandom_range(0, 39) == 0) sw_fast = ~sw_fast;
         if (hold == 0) begin
            key_step_n = ~key_step_n;
            hold = int'($urandom_range(1, 10));
         end else begin
            hold--;
         end
         rst = ($urandom_range(0, 499) == 0);
         @(negedge clk50mhz);
      end
      rst = 1'b0;
      tick(2);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
      $finish;
   end

endmodule

// File: doc/lfsr_step_ctrl.md
# lfsr_step_ctrl

Step-enable generator that sits directly upstream of the 8-bit LFSR display stage and replaces its free-running divided clock with a single-cycle `step_en` strobe in the 50 MHz domain. It supports free-run at a slow or fast rate, and single-stepping from a debounced pushbutton while paused. The LFSR stage advances exactly once per `step_en` cycle. `step_en` is never used as a clock.

## Interface
- `SLOW_DIV`, 50_000_000: cycles between steps in slow run (1 Hz).
- `FAST_DIV`, 6_250_000: cycles between steps in fast run (8 Hz).
- `DB_CYCLES`, 500_000: consecutive stable synchronized samples required to accept a key level change (10 ms).
- `CNT_W`, 26: prescaler width. Must satisfy 2^CNT_W ≥ max(SLOW_DIV, FAST_DIV).
- `clk50mhz`  in  1  sole clock. All logic is on its rising edge.
- `rst`  in  1  synchronous, active-high reset.
- `key_step_n`  in  1  raw pushbutton, active-low, asynchronous.
- `sw_run`  in  1  raw switch, asynchronous: 1 = free-run, 0 = paused.
- `sw_fast`  in  1  raw switch, asynchronous: 1 = FAST_DIV, 0 = SLOW_DIV.
- `step_en`  out  1  one-cycle advance strobe to the LFSR stage.
- `led_step`  out  1  toggles on every `step_en`.
- `running`  out  1  FSM is in RUN.
- `step_count`  out  16  total strobes issued since reset. Wraps 0xFFFF→0x0000.

## Operation
- Input conditioning:
  - `key_step_n`, `sw_run` and `sw_fast` each pass through a 2-flop synchronizer. Synchronizer flops reset to 1, 0 and 0 respectively.
  - The key is then debounced. The debounced level updates only after DB_CYCLES consecutive identical synchronized samples that differ from the current debounced level. Any differing sample restarts the count.
  - `press` is a one-cycle pulse on the debounced 1→0 transition. Release generates nothing.
- FSM with states PAUSED and RUN. Reset state is PAUSED.
  - PAUSED→RUN when synced `sw_run`=1. The prescaler clears on entry.
  - RUN→PAUSED when synced `sw_run`=0. The prescaler clears and any pending terminal count is dropped.
- Prescaler (RUN only):
  - `div` = FAST_DIV if synced `sw_fast`=1, else SLOW_DIV.
  - Counts 0..div-1. At count ≥ div-1 it emits `step_en` and returns to 0.
  - The ≥ compare makes a fast-switch mid-count with count already past FAST_DIV-1 fire on the next cycle, not wrap through 2^CNT_W.
- In PAUSED, each `press` produces exactly one `step_en`.
- In RUN, `press` is ignored.
- Simultaneous events:
  - If `press` coincides with a PAUSED→RUN transition, the press is discarded.
  - If `press` occurs on the exit cycle RUN→PAUSED, it is not honoured, because the FSM is still in RUN that cycle.
- `step_en` is never asserted on two consecutive cycles unless div=1.
- `led_step` and `step_count` update on the same edge that registers `step_en`=1.
- Reset values: `step_en`=0, `led_step`=0, `running`=0, `step_count`=0, prescaler=0, debounced key=1, FSM=PAUSED.
- `rst` asserted mid-count or mid-debounce aborts everything. No strobe is emitted during or in the cycle after reset.

## Timing
- Key path: raw edge → 2 cycles synchronization → DB_CYCLES stable samples → debounced level registered → `press` → `step_en` registered 1 cycle later. Worst-case latency is DB_CYCLES+4 cycles from a clean raw edge.
- Run path:
  - First `step_en` occurs `div` cycles after the first cycle the FSM is in RUN. Steady period is exactly `div` cycles.
  - Switch path latency: 2 synchronizer cycles + 1 FSM cycle.
- `step_en` is registered: asserted for exactly one `clk50mhz` cycle. The downstream LFSR samples it on the next edge.

## Structure
- Package `lfsr_ctrl_pkg` holds:
  - the FSM state enum (PAUSED, RUN);
  - the default SLOW_DIV, FAST_DIV and DB_CYCLES constants;
  - the `step_count` width localparam.
- Sub-module `key_debounce` (parameter DB_CYCLES) contains the synchronizer, stable counter, debounced level and `press` pulse. It is instantiated once.
- The top level holds the switch synchronizers, FSM, prescaler and outputs.

## Test plan
All tests use SLOW_DIV=8, FAST_DIV=2, DB_CYCLES=4, CNT_W=4.
- Reset, all inputs idle, `sw_run`=0 → after reset all outputs stay 0 and `step_count`=0 for 100 cycles.
- Paused stepping: `key_step_n` low for 10 cycles, then high, repeated 3× → exactly 3 `step_en` pulses, `step_count`=3, `led_step`=1.
- Bounce rejection: key toggled every 2 cycles for 20 cycles, then held low → exactly 1 `step_en`, ≤8 cycles after the final fall.
- Slow run: `sw_run`=1 for 80 cycles → `step_en` every 8 cycles, first pulse 8 cycles after `running`=1, 9–10 pulses total.
- Mid-count rate change: in RUN with prescaler=5, set `sw_fast`=1 → `step_en` fires within 3 cycles, then every 2 cycles. Also key presses in RUN produce no extra pulses.
- Reset mid-run: `rst` pulsed at prescaler=6 → no `step_en` for the next 8 cycles after reset deassert with `sw_run` held 1, and `step_count` restarts from 0.
